polyline_draw: RTL and testbench

POLYLINE_DRAW -- requirements
Module: polyline_draw

---
 rtl/polyline_pkg.sv | 33 +++
 rtl/polyline_draw_line_engine.sv | 81 ++++++++
 rtl/polyline_draw.sv | 141 ++++++++++++++
 tb/tb_polyline_draw.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/polyline_pkg.sv
`default_nettype none
// ==========================================================================
// polyline_pkg : FSM state type, default widths, colour constants | Rev 1.0
// ==========================================================================
package polyline_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int DEF_XW        = 8;
  localparam int DEF_YW        = 7;
  localparam int DEF_MAX_VERTS = 8;
  localparam int DEF_CW        = 3;

  localparam logic [2:0] BLACK   = 3'b000;
  localparam logic [2:0] BLUE    = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] CYAN    = 3'b011;
  localparam logic [2:0] RED     = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] YELLOW  = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/polyline_draw_line_engine.sv
`default_nettype none
// ==========================================================================
// line_engine : per-segment all-octant Bresenham stepper (load/step/last)
// Revision 1.0
// ==========================================================================
module line_engine
  import polyline_pkg::*;
#(
  parameter int XW = DEF_XW,
  parameter int YW = DEF_YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] x1,
  input  logic [YW-1:0] y1,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam int DW = max2(XW, YW) + 2;

  logic signed [DW-1:0] ddx, ddy, adx, ady;
  logic signed [DW-1:0] dx, dy, err, err_n, cnt;
  logic signed [DW:0]   e2, dx_e, dy_e;
  logic                 sx_neg, sy_neg, mv_x, mv_y;

  always_comb begin
    ddx = $signed({{(DW-XW){1'b0}}, x1}) - $signed({{(DW-XW){1'b0}}, x0});
    ddy = $signed({{(DW-YW){1'b0}}, y1}) - $signed({{(DW-YW){1'b0}}, y0});
    adx = (ddx < 0) ? -ddx : ddx;
    ady = (ddy < 0) ? -ddy : ddy;
  end

  // dy is held negated so both axis decisions compare against 2*err directly
  always_comb begin
    e2    = {err, 1'b0};
    dx_e  = {dx[DW-1], dx};
    dy_e  = {dy[DW-1], dy};
    mv_x  = (e2 >= dy_e);
    mv_y  = (e2 <= dx_e);
    err_n = err;
    if (mv_x) err_n = err_n + dy;
    if (mv_y) err_n = err_n + dx;
  end

  assign last = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x      <= '0;
      y      <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      cnt    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else if (load) begin
      x      <= x0;
      y      <= y0;
      dx     <= adx;
      dy     <= -ady;
      err    <= adx - ady;
      cnt    <= (adx > ady) ? adx : ady;
      sx_neg <= (ddx < 0);
      sy_neg <= (ddy < 0);
    end else if (step) begin
      err <= err_n;
      cnt <= cnt - DW'(1);
      if (mv_x) x <= sx_neg ? (x - XW'(1)) : (x + XW'(1));
      if (mv_y) y <= sy_neg ? (y - YW'(1)) : (y + YW'(1));
    end
  end

endmodule
`default_nettype wire

// File: rtl/polyline_draw.sv
`default_nettype none
// ==========================================================================
// polyline_draw : vertex table + FSM drawing num_verts-1 Bresenham segments;
// optional POLYLINE_CLOSE_EN adds a closing segment.  Revision 1.0
// ==========================================================================
module polyline_draw
  import polyline_pkg::*;
#(
  parameter int XW        = DEF_XW,
  parameter int YW        = DEF_YW,
  parameter int MAX_VERTS = DEF_MAX_VERTS,
  parameter int CW        = DEF_CW
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [$clog2(MAX_VERTS+1)-1:0] num_verts,
  input  logic [CW-1:0]                  colour,
`ifdef POLYLINE_CLOSE_EN
  input  logic                           close,
`endif
  input  logic                           vert_we,
  input  logic [$clog2(MAX_VERTS)-1:0]   vert_addr,
  input  logic [XW-1:0]                  vert_x,
  input  logic [YW-1:0]                  vert_y,
  output logic                           busy,
  output logic                           done,
  output logic [XW-1:0]                  vga_x,
  output logic [YW-1:0]                  vga_y,
  output logic [CW-1:0]                  vga_colour,
  output logic                           vga_plot
);

  localparam int NW = $clog2(MAX_VERTS+1);
  localparam int AW = $clog2(MAX_VERTS);

  logic [XW-1:0] tab_x [MAX_VERTS];
  logic [YW-1:0] tab_y [MAX_VERTS];

  state_t        state;
  logic [NW-1:0] nv, nseg, seg;
  logic [NW-1:0] nv_c, nseg_c, seg_nx, b_sel;
  logic [AW-1:0] a_idx, b_idx;
  logic [XW-1:0] eng_x;
  logic [YW-1:0] eng_y;
  logic          eng_last;

  // Table has no reset so vertices survive a reset pulse
  always_ff @(posedge clk) begin
    if (vert_we && !busy && (int'(vert_addr) < MAX_VERTS)) begin
      tab_x[vert_addr] <= vert_x;
      tab_y[vert_addr] <= vert_y;
    end
  end

  always_comb begin
    nv_c   = (int'(num_verts) > MAX_VERTS) ? NW'(MAX_VERTS) : num_verts;
    nseg_c = '0;
    if (nv_c >= NW'(2)) nseg_c = nv_c - NW'(1);
`ifdef POLYLINE_CLOSE_EN
    if (close && (nv_c >= NW'(3))) nseg_c = nv_c;
`endif
  end

  // The closing segment wraps its end index back to vertex 0
  always_comb begin
    seg_nx = seg + NW'(1);
    b_sel  = (seg_nx >= nv) ? '0 : seg_nx;
    a_idx  = AW'(seg);
    b_idx  = AW'(b_sel);
  end

  line_engine #(
    .XW (XW),
    .YW (YW)
  ) u_engine (
    .clk   (clk),
    .rst_n (rst_n),
    .load  ((state == S_LOAD) && (nseg != '0)),
    .step  (state == S_DRAW),
    .x0    (tab_x[a_idx]),
    .y0    (tab_y[a_idx]),
    .x1    (tab_x[b_idx]),
    .y1    (tab_y[b_idx]),
    .x     (eng_x),
    .y     (eng_y),
    .last  (eng_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      nv         <= '0;
      nseg       <= '0;
      seg        <= '0;
    end else begin
      vga_plot <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state      <= S_LOAD;
            busy       <= 1'b1;
            done       <= 1'b0;
            nv         <= nv_c;
            nseg       <= nseg_c;
            seg        <= '0;
            vga_colour <= colour;
          end else if (state == S_DONE) begin
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        S_LOAD: begin
          state <= (nseg == '0) ? S_DONE : S_DRAW;
        end
        S_DRAW: begin
          vga_plot <= 1'b1;
          vga_x    <= eng_x;
          vga_y    <= eng_y;
          if (eng_last) begin
            if (seg_nx < nseg) begin
              seg   <= seg_nx;
              state <= S_LOAD;
            end else begin
              state <= S_DONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_polyline_draw.sv
`default_nettype none
// ==========================================================================
// tb_polyline_draw : table vectors, corner sequences and random polylines
// Revision 1.0
// ==========================================================================
module tb_polyline_draw;
  import polyline_pkg::*;

  localparam int XW = 8, YW = 7, MV = 8, CW = 3;
  localparam int NW = $clog2(MV+1), AW = $clog2(MV);

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, vert_we = 1'b0;
  logic [NW-1:0] num_verts = '0;
  logic [CW-1:0] colour = '0;
  logic [AW-1:0] vert_addr = '0;
  logic [XW-1:0] vert_x = '0;
  logic [YW-1:0] vert_y = '0;
`ifdef POLYLINE_CLOSE_EN
  logic          close = 1'b0;
`endif
  logic          busy, done, vga_plot;
  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;

  polyline_draw dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_verts  (num_verts),
    .colour     (colour),
`ifdef POLYLINE_CLOSE_EN
    .close      (close),
`endif
    .vert_we    (vert_we),
    .vert_addr  (vert_addr),
    .vert_x     (vert_x),
    .vert_y     (vert_y),
    .busy       (busy),
    .done       (done),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  logic [17:0] got_q[$], exp_q[$];
  int mx[MV], my[MV];

  always @(negedge clk) if (vga_plot === 1'b1) got_q.push_back({vga_x, vga_y, vga_colour});

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic logic [14:0] pix(input int x, input int y);
    return {XW'(x), YW'(y)};
  endfunction

  // Reference: plain integer Bresenham for each segment, endpoints inclusive
  function automatic void model_line(input int x0, input int y0, input int x1, input int y1, input int col);
    int dx = (x1 > x0) ? x1 - x0 : x0 - x1;
    int dy = -((y1 > y0) ? y1 - y0 : y0 - y1);
    int sx = (x0 < x1) ? 1 : -1;
    int sy = (y0 < y1) ? 1 : -1;
    int err = dx + dy;
    int x = x0, y = y0, e2;
    while (1) begin
      exp_q.push_back({XW'(x), YW'(y), CW'(col)});
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endfunction

  function automatic void model(input int nv, input int col, input bit cl);
    int n = (nv > MV) ? MV : nv;
    int segs;
    bit c = 1'b0;
`ifdef POLYLINE_CLOSE_EN
    c = cl;
`else
    c = cl & 1'b0;
`endif
    exp_q.delete();
    if (n < 2) return;
    segs = n - 1;
    if (c && n >= 3) segs = n;
    for (int s = 0; s < segs; s++)
      model_line(mx[s], my[s], mx[(s+1) % n], my[(s+1) % n], col);
  endfunction

  task automatic write_vert(input int a, input int x, input int y);
    vert_we = 1'b1; vert_addr = AW'(a); vert_x = XW'(x); vert_y = YW'(y);
    @(posedge clk); #1;
    vert_we = 1'b0;
    mx[a] = x; my[a] = y;
  endtask

  // inject >= 0 pulses start and a table write at that cycle of the run
  task automatic run(input int nv, input logic [CW-1:0] col, input bit cl, input int inject,
                     output bit busy_gap, output bit timed_out);
    got_q.delete();
    model(nv, int'(col), cl);
    busy_gap = 1'b0; timed_out = 1'b1;
    num_verts = NW'(nv); colour = col; start = 1'b1;
`ifdef POLYLINE_CLOSE_EN
    close = cl;
`endif
    @(posedge clk); #1;
    start = 1'b0; num_verts = '0; colour = ~col;
`ifdef POLYLINE_CLOSE_EN
    close = 1'b0;
`endif
    for (int c = 0; c < 3000; c++) begin
      if (c == inject) begin
        start = 1'b1; vert_we = 1'b1; vert_addr = '0; vert_x = 8'hAA; vert_y = 7'h55;
      end else begin
        start = 1'b0; vert_we = 1'b0;
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin timed_out = 1'b0; break; end
      if (busy !== 1'b1) busy_gap = 1'b1;
    end
    start = 1'b0; vert_we = 1'b0;
  endtask

  task automatic cmp_seq(input string name);
    int bad = 0;
    check({name, " plot count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad++;
    check({name, " pixel errors"}, bad, 0);
  endtask

  typedef struct {
    int nv;
    int x0, y0, x1, y1, x2, y2;
    logic [2:0] col;
    int exp_n;
    int fx, fy, lx, ly;
  } vec_t;

  vec_t vt[8];

  initial begin
    bit gap, to;
    int seen, twice;

    vt[0] = '{2,  80, 90,  60, 65,  0,  0, RED,     26,  80, 90,  60, 65};
    vt[1] = '{3,  10, 10,  20, 10, 20, 30, GREEN,   32,  10, 10,  20, 30};
    vt[2] = '{2,   5,  5,   5,  5,  0,  0, BLUE,     1,   5,  5,   5,  5};
    vt[3] = '{2,   0,  0, 255,127,  0,  0, WHITE,  256,   0,  0, 255,127};
    vt[4] = '{2,  30,100,  40,  0,  0,  0, YELLOW, 101,  30,100,  40,  0};
    vt[5] = '{3, 100, 20,  90, 25, 95, 10, CYAN,    27, 100, 20,  95, 10};
    vt[6] = '{0,   1,  2,   3,  4,  5,  6, MAGENTA,  0,   0,  0,   0,  0};
    vt[7] = '{1,   1,  2,   3,  4,  5,  6, RED,      0,   0,  0,   0,  0};

    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset plot", vga_plot, 0);
    check("reset xy", {vga_x, vga_y}, 0);
    check("reset colour", vga_colour, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      write_vert(0, vt[i].x0, vt[i].y0);
      write_vert(1, vt[i].x1, vt[i].y1);
      write_vert(2, vt[i].x2, vt[i].y2);
      run(vt[i].nv, vt[i].col, 1'b0, -1, gap, to);
      check($sformatf("vec%0d timeout", i), to, 0);
      check($sformatf("vec%0d count", i), got_q.size(), vt[i].exp_n);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d first", i), got_q[0][17:3], pix(vt[i].fx, vt[i].fy));
        check($sformatf("vec%0d last", i), got_q[got_q.size()-1][17:3], pix(vt[i].lx, vt[i].ly));
        check($sformatf("vec%0d colour", i), got_q[got_q.size()-1][2:0], vt[i].col);
      end
      check($sformatf("vec%0d busy gap", i), gap, 0);
      cmp_seq($sformatf("vec%0d", i));
      if (i == 1) begin
        twice = 0;
        foreach (got_q[k]) if (got_q[k][17:3] == pix(20, 10)) twice++;
        check("shared vertex plots", twice, 2);
      end
    end

    // first plot latency and busy timing
    write_vert(0, 80, 90);
    write_vert(1, 60, 65);
    got_q.delete();
    num_verts = NW'(2); colour = RED; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("busy after start", busy, 1);
    @(posedge clk); #1;
    check("plot at +1", vga_plot, 0);
    @(posedge clk); #1;
    check("plot at +2", vga_plot, 1);
    check("first pixel", {vga_x, vga_y}, pix(80, 90));
    check("first colour", vga_colour, RED);
    for (int c = 0; c < 100 && done !== 1'b1; c++) begin @(posedge clk); #1; end
    check("latency run done", done, 1);

    // single vertex: done two cycles after start, no plots
    got_q.delete();
    num_verts = NW'(1); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    check("nv1 done at +1", done, 0);
    @(posedge clk); #1;
    check("nv1 done at +2", done, 1);
    check("nv1 busy at +2", busy, 0);
    check("nv1 plots", got_q.size(), 0);

    // asynchronous reset during the 5th pixel, then full redraw
    got_q.delete();
    num_verts = NW'(2); colour = RED; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    seen = 0;
    for (int c = 0; c < 100 && seen < 5; c++) begin
      @(posedge clk); #1;
      if (vga_plot === 1'b1) seen++;
    end
    check("plots before reset", seen, 5);
    #2 rst_n = 1'b0;
    #1;
    check("async rst plot", vga_plot, 0);
    check("async rst busy", busy, 0);
    check("async rst xy", {vga_x, vga_y}, 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run(2, RED, 1'b0, -1, gap, to);
    check("post-reset timeout", to, 0);
    cmp_seq("post-reset");

    // start and table write while busy are ignored
    run(2, GREEN, 1'b0, 3, gap, to);
    check("inject timeout", to, 0);
    cmp_seq("inject");
    run(2, GREEN, 1'b0, -1, gap, to);
    cmp_seq("inject table kept");

    // num_verts above MAX_VERTS clamps
    for (int k = 0; k < MV; k++) write_vert(k, $urandom_range(0, 255), $urandom_range(0, 127));
    run(12, BLUE, 1'b0, -1, gap, to);
    check("clamp timeout", to, 0);
    cmp_seq("clamp");

    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(2, MV);
      for (int k = 0; k < n; k++) write_vert(k, $urandom_range(0, 255), $urandom_range(0, 127));
      run(n, CW'($urandom_range(0, 7)), 1'b0, -1, gap, to);
      check($sformatf("rand%0d timeout", r), to, 0);
      cmp_seq($sformatf("rand%0d", r));
    end

`ifdef POLYLINE_CLOSE_EN
    write_vert(0, 10, 10);
    write_vert(1, 20, 10);
    write_vert(2, 20, 30);
    run(3, RED, 1'b1, -1, gap, to);
    check("close count", got_q.size(), 53);
    if (got_q.size() > 0) check("close last", got_q[got_q.size()-1][17:3], pix(10, 10));
    cmp_seq("close");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, tests %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
